// File: rtl/dram_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dram_arb_pkg                                                      |
// | Brief   : Shared types and constants for the data-DRAM port arbiter.        |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU   = 1'b0;
   localparam logic PORT_AUX   = 1'b1;
   localparam int   WAIT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dram_port_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_pick2                                                          |
// | Brief   : Combinational two-way round-robin picker.                         |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant,
   output logic       idx
);

   // On a tie the port that did not win last time goes next.
   always_comb begin
      grant = 2'b00;
      idx   = 1'b0;
      if (valid == 2'b11) begin
         idx   = ~last;
         grant = last ? 2'b01 : 2'b10;
      end else begin
         idx   = valid[1];
         grant = valid;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dram_port_arbiter                                                 |
// | Brief   : Round-robin arbiter and sequencer for the single-port data DRAM.  |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int RD_WAIT = 1
) (
   input  logic                   fpga_clk,
   input  logic                   fpga_rst_n,
   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_write,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   output logic [1:0]             req_ready,
   output logic [1:0]             rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic [ADDR_W-1:0]      mem_a,
   output logic [DATA_W-1:0]      mem_d,
   output logic                   mem_we,
   input  logic [DATA_W-1:0]      mem_spo
);

   localparam logic [WAIT_CNT_W-1:0] c_rd_wait = WAIT_CNT_W'(RD_WAIT);
   localparam logic [WAIT_CNT_W-1:0] c_one     = WAIT_CNT_W'(1);

   arb_state_t              r_state;
   logic                    r_last_grant;
   logic                    r_owner;
   logic                    r_write;
   logic [WAIT_CNT_W-1:0]   r_wait_cnt;

   logic [1:0]              w_grant;
   logic                    w_idx;
   logic                    w_unused_addr_lsbs;

   // Byte offset bits are never used: the DRAM is word-addressed.
   assign w_unused_addr_lsbs = ^{req_addr[0][1:0], req_addr[1][1:0]};

   rr_pick2 u_pick (
      .valid (req_valid),
      .last  (r_last_grant),
      .grant (w_grant),
      .idx   (w_idx)
   );

   assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;

   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= PORT_AUX;
         r_owner      <= PORT_CPU;
         r_write      <= 1'b0;
         r_wait_cnt   <= '0;
         rsp_valid    <= 2'b00;
         rsp_rdata    <= '0;
         mem_a        <= '0;
         mem_d        <= '0;
         mem_we       <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         mem_we    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|req_valid) begin
                  r_owner      <= w_idx;
                  r_last_grant <= w_idx;
                  r_write      <= req_write[w_idx];
                  mem_a        <= {2'b00, req_addr[w_idx][ADDR_W-1:2]};
                  mem_d        <= req_wdata[w_idx];
                  mem_we       <= req_write[w_idx];
                  r_wait_cnt   <= req_write[w_idx] ? c_one : c_rd_wait;
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               r_wait_cnt <= r_wait_cnt - 1'b1;
               if (r_wait_cnt == c_one) begin
                  if (!r_write) begin
                     rsp_rdata <= mem_spo;
                  end
                  rsp_valid[r_owner] <= 1'b1;
                  r_state            <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dram_port_arbiter                                              |
// | Brief   : Scoreboard bench for dram_port_arbiter (RD_WAIT=1 and RD_WAIT=3). |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_dram_port_arbiter;

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] data;
   } exp_t;

   logic fpga_clk = 1'b0;
   logic fpga_rst_n;
   always #5 fpga_clk = ~fpga_clk;

   // RD_WAIT=1 instance
   logic [1:0]       req_valid, req_write, req_ready, rsp_valid;
   logic [1:0][15:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [31:0]      rsp_rdata, mem_d, mem_spo;
   logic [15:0]      mem_a;
   logic             mem_we;

   // RD_WAIT=3 instance
   logic [1:0]       b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
   logic [1:0][15:0] b_req_addr;
   logic [1:0][31:0] b_req_wdata;
   logic [31:0]      b_rsp_rdata, b_mem_d, b_mem_spo;
   logic [15:0]      b_mem_a;
   logic             b_mem_we;

   logic [31:0] dram [0:255];
   assign mem_spo = dram[mem_a[7:0]];

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rd;

   dram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_WAIT(1)) dut (
      .fpga_clk(fpga_clk), .fpga_rst_n(fpga_rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
      .mem_spo(mem_spo)
   );

   dram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_WAIT(3)) dut3 (
      .fpga_clk(fpga_clk), .fpga_rst_n(fpga_rst_n),
      .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rsp_rdata), .mem_a(b_mem_a), .mem_d(b_mem_d), .mem_we(b_mem_we),
      .mem_spo(b_mem_spo)
   );

   task automatic test_reset();
      fpga_rst_n = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
      b_mem_spo = '0;
      repeat (2) @(negedge fpga_clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
      checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL rst_mem_a got %h want 0", mem_a); end
      checks++; if (mem_d !== 32'h0) begin errors++; $display("FAIL rst_mem_d got %h want 0", mem_d); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
      checks++; if (b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata3 got %h want 0", b_rsp_rdata); end
      @(posedge fpga_clk); #1;
      fpga_rst_n = 1'b1;
      last_rd = 32'h0;
      @(negedge fpga_clk);
   endtask

   task automatic test_single_read();
      exp_t e;
      @(posedge fpga_clk); #1;
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 16'h0008;
      @(negedge fpga_clk); // cycle 0
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready got %b want 01", req_ready); end
      sb.push_back('{valid: 2'b01, data: dram[2]});
      @(posedge fpga_clk); #1;
      req_valid = 2'b00;
      @(negedge fpga_clk); // cycle 1
      checks++; if (mem_a !== 16'h0002) begin errors++; $display("FAIL rd_mem_a got %h want 0002", mem_a); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_rsp got %b want 00", rsp_valid); end
      @(negedge fpga_clk); // cycle 2
      e = sb.pop_front();
      checks++; if (rsp_valid !== e.valid) begin errors++; $display("FAIL rd_rsp_valid got %b want %b", rsp_valid, e.valid); end
      checks++; if (rsp_rdata !== e.data) begin errors++; $display("FAIL rd_rdata got %h want %h", rsp_rdata, e.data); end
      last_rd = e.data;
   endtask

   task automatic test_single_write();
      exp_t e;
      @(posedge fpga_clk); #1;
      req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 16'h0010; req_wdata[1] = 32'h12345678;
      @(negedge fpga_clk); // cycle 0
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_ready got %b want 10", req_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_c0 got %b want 0", mem_we); end
      sb.push_back('{valid: 2'b10, data: last_rd});
      @(posedge fpga_clk); #1;
      req_valid = 2'b00; req_write = 2'b00;
      @(negedge fpga_clk); // cycle 1
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we_c1 got %b want 1", mem_we); end
      checks++; if (mem_a !== 16'h0004) begin errors++; $display("FAIL wr_mem_a got %h want 0004", mem_a); end
      checks++; if (mem_d !== 32'h12345678) begin errors++; $display("FAIL wr_mem_d got %h want 12345678", mem_d); end
      @(negedge fpga_clk); // cycle 2
      e = sb.pop_front();
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_c2 got %b want 0", mem_we); end
      checks++; if (rsp_valid !== e.valid) begin errors++; $display("FAIL wr_rsp_valid got %b want %b", rsp_valid, e.valid); end
      checks++; if (rsp_rdata !== e.data) begin errors++; $display("FAIL wr_rdata_kept got %h want %h", rsp_rdata, e.data); end
   endtask

   task automatic test_contention();
      exp_t e;
      int   k[2];
      int   g;
      int   ngrant = 0;
      int   nrsp = 0;
      int   cyc = 0;
      k[0] = 0; k[1] = 0;
      @(posedge fpga_clk); #1;
      req_write = 2'b00;
      req_addr[0] = 16'h0020; req_addr[1] = 16'h0024;
      req_valid = 2'b11;
      while (nrsp < 4 && cyc < 60) begin
         @(negedge fpga_clk);
         cyc++;
         g = -1;
         if (req_ready !== 2'b00) begin
            g = int'(req_ready[1]);
            checks++;
            if (req_ready !== ((ngrant % 2) == 1 ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL cont_grant%0d got %b want %0d", ngrant, req_ready, ngrant % 2);
            end
            sb.push_back('{valid: 2'(1 << g), data: dram[8 + 2*k[g] + g]});
            ngrant++;
         end
         if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL cont_spurious_rsp got %b want 00", rsp_valid);
            end else begin
               e = sb.pop_front();
               checks++; if (rsp_valid !== e.valid) begin errors++; $display("FAIL cont_rsp_route got %b want %b", rsp_valid, e.valid); end
               checks++; if (rsp_rdata !== e.data) begin errors++; $display("FAIL cont_rdata got %h want %h", rsp_rdata, e.data); end
               last_rd = e.data;
            end
            nrsp++;
         end
         @(posedge fpga_clk); #1;
         if (g >= 0) begin
            k[g]++;
            if (k[g] >= 2) req_valid[g] = 1'b0;
            else req_addr[g] = 16'(32'h20 + 8*k[g] + 4*g);
         end
      end
      checks++;
      if (nrsp < 4) begin errors++; $display("FAIL cont_timeout got %0d rsp want 4", nrsp); end
      req_valid = 2'b00;
      sb.delete();
   endtask

   task automatic test_wait_states();
      exp_t e;
      @(posedge fpga_clk); #1;
      b_req_valid = 2'b01; b_req_write = 2'b00; b_req_addr[0] = 16'h0030;
      @(negedge fpga_clk); // cycle 0
      checks++; if (b_req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready got %b want 01", b_req_ready); end
      sb.push_back('{valid: 2'b01, data: 32'h0000000C});
      @(posedge fpga_clk); #1;
      b_req_valid = 2'b00; b_mem_spo = 32'hA;
      @(negedge fpga_clk); // cycle 1
      checks++; if (b_mem_a !== 16'h000C) begin errors++; $display("FAIL ws_mem_a got %h want 000c", b_mem_a); end
      @(posedge fpga_clk); #1;
      b_mem_spo = 32'hB;
      @(negedge fpga_clk); // cycle 2
      checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL ws_early_rsp2 got %b want 00", b_rsp_valid); end
      @(posedge fpga_clk); #1;
      b_mem_spo = 32'hC;
      @(negedge fpga_clk); // cycle 3
      checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL ws_early_rsp3 got %b want 00", b_rsp_valid); end
      @(posedge fpga_clk); #1;
      b_mem_spo = 32'hD;
      @(negedge fpga_clk); // cycle 4
      e = sb.pop_front();
      checks++; if (b_rsp_valid !== e.valid) begin errors++; $display("FAIL ws_rsp_valid got %b want %b", b_rsp_valid, e.valid); end
      checks++; if (b_rsp_rdata !== e.data) begin errors++; $display("FAIL ws_rdata got %h want %h", b_rsp_rdata, e.data); end
      @(negedge fpga_clk); // cycle 5
      checks++; if (b_rsp_valid !== 2'b00) begin errors++; $display("FAIL ws_rsp_pulse got %b want 00", b_rsp_valid); end
      checks++; if (b_rsp_rdata !== e.data) begin errors++; $display("FAIL ws_rdata_hold got %h want %h", b_rsp_rdata, e.data); end
   endtask

   task automatic test_reset_mid_write();
      exp_t e;
      @(posedge fpga_clk); #1;
      req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 16'h0040; req_wdata[0] = 32'hCAFEF00D;
      @(negedge fpga_clk); // cycle 0
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmw_ready got %b want 01", req_ready); end
      @(posedge fpga_clk); #1;
      req_valid = 2'b00; req_write = 2'b00;
      @(negedge fpga_clk); // cycle 1, ACCESS
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmw_we_before got %b want 1", mem_we); end
      #2;
      fpga_rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we_async got %b want 0", mem_we); end
      checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL rmw_mem_a got %h want 0", mem_a); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rmw_rdata got %h want 0", rsp_rdata); end
      repeat (3) begin
         @(negedge fpga_clk);
         checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmw_rsp_in_rst got %b want 00", rsp_valid); end
      end
      @(posedge fpga_clk); #1;
      fpga_rst_n = 1'b1;
      req_valid = 2'b11; req_addr[0] = 16'h0040; req_addr[1] = 16'h0044;
      @(negedge fpga_clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmw_tie got %b want 01", req_ready); end
      sb.push_back('{valid: 2'b01, data: dram[16]});
      @(posedge fpga_clk); #1;
      req_valid = 2'b00;
      @(negedge fpga_clk);
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmw_rsp_c1 got %b want 00", rsp_valid); end
      @(negedge fpga_clk);
      e = sb.pop_front();
      checks++; if (rsp_valid !== e.valid) begin errors++; $display("FAIL rmw_rsp_valid got %b want %b", rsp_valid, e.valid); end
      checks++; if (rsp_rdata !== e.data) begin errors++; $display("FAIL rmw_rdata_after got %h want %h", rsp_rdata, e.data); end
   endtask

   task automatic test_early_withdraw();
      exp_t e;
      @(posedge fpga_clk); #1;
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 16'h0008;
      @(negedge fpga_clk); // cycle 0
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ew_ready got %b want 01", req_ready); end
      sb.push_back('{valid: 2'b01, data: dram[2]});
      @(posedge fpga_clk); #1;
      req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 16'h0050; req_wdata[1] = 32'h55AA55AA;
      @(negedge fpga_clk); // cycle 1
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ew_ready_busy got %b want 00", req_ready); end
      @(posedge fpga_clk); #1;
      req_valid = 2'b00; req_write = 2'b00;
      @(negedge fpga_clk); // cycle 2
      e = sb.pop_front();
      checks++; if (rsp_valid !== e.valid) begin errors++; $display("FAIL ew_rsp_valid got %b want %b", rsp_valid, e.valid); end
      checks++; if (rsp_rdata !== e.data) begin errors++; $display("FAIL ew_rdata got %h want %h", rsp_rdata, e.data); end
      repeat (5) begin
         @(negedge fpga_clk);
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ew_mem_we got %b want 0", mem_we); end
         checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL ew_rsp got %b want 00", rsp_valid); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) dram[i] = 32'h1000_0000 + 32'(i);
      dram[2]  = 32'hDEADBEEF;
      dram[16] = 32'h0BADC0DE;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_wait_states();
      test_reset_mid_write();
      test_early_withdraw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter and sequencer for the single-ported data DRAM in the miniRV SoC. It sits between the CPU data port (port 0) and an auxiliary port (port 1, debug/loader) on one side and the DRAM on the other. It grants requesters round-robin and drives DRAM address, write data and write enable from registered state. It also generates the ready/response handshake that the CPU's external-memory interface consumes.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width of requests and of `mem_a`.
- `DATA_W`, 32: data width.
- `RD_WAIT`, 1: cycles the DRAM address is held before read data is sampled. Legal range is 1..15.

Ports:
- `fpga_clk` in, 1: sole clock.
- `fpga_rst_n` in, 1: asynchronous active-low reset.
- `req_valid[1:0]` in, 2: request valid, one bit per port.
- `req_write[1:0]` in, 2: 1 = write, 0 = read.
- `req_addr[1:0]` in, 2×ADDR_W: byte address.
- `req_wdata[1:0]` in, 2×DATA_W: write data.
- `req_ready[1:0]` out, 2: accept strobe. Combinational; at most one bit is set.
- `rsp_valid[1:0]` out, 2: one-cycle completion pulse to the owning port.
- `rsp_rdata` out, DATA_W: read data, shared by both ports and qualified by `rsp_valid`.
- `mem_a` out, ADDR_W: DRAM word address, `{2'b00, addr[ADDR_W-1:2]}`.
- `mem_d` out, DATA_W: DRAM write data.
- `mem_we` out, 1: DRAM write enable.
- `mem_spo` in, DATA_W: DRAM asynchronous read data.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any `req_valid` bit is set, the arbiter picks a winner. A single requester wins outright. With both valid, the port ≠ `last_grant` wins.
  - `req_ready[winner]`=1 in the same cycle.
  - On the clock edge the block latches addr, wdata, write and owner, updates `last_grant`, loads `wait_cnt` = RD_WAIT for a read or 1 for a write, and moves to ACCESS.
- ACCESS:
  - `mem_a` and `mem_d` are driven from the latched registers.
  - `mem_we`=1 only for a latched write. It is asserted for exactly one cycle.
  - `wait_cnt` decrements each cycle. When it reaches 1, a read samples `mem_spo` into `rsp_rdata`, and the FSM moves to RESP.
- RESP:
  - `rsp_valid[owner]`=1 for one cycle, then the FSM returns to IDLE.
  - For a write, `rsp_rdata` is unchanged.
- Requester rules:
  - A requester holds valid, addr and wdata stable until it sees ready.
  - Dropping valid before ready is legal and has no effect.
  - Address bits [1:0] are ignored; byte strobes are not supported.
- `rsp_rdata` holds its value until the next read completes.
- Reset values: state=IDLE, `last_grant`=1 (so port 0 wins the first tie), `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `mem_a`=0, `mem_d`=0, `mem_we`=0, `wait_cnt`=0.
- Reset asserted mid-transaction: outputs return to reset values immediately, including an in-progress `mem_we` being forced to 0. No `rsp_valid` is produced for the aborted access, and arbitration restarts after release.

## Timing
- Accept edge = cycle 0.
- Read:
  - ACCESS spans cycles 1..RD_WAIT.
  - `rsp_valid` and the new `rsp_rdata` appear in cycle RD_WAIT+1.
  - Next accept is possible in cycle RD_WAIT+2.
- Write:
  - `mem_we`=1 in cycle 1 only.
  - `rsp_valid` in cycle 2.
  - Next accept in cycle 3.
- `req_ready` is a combinational function of `req_valid`, state and `last_grant`. It has no path from `mem_spo`.
- All outputs except `req_ready` are registered.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; no port waits more than one transaction.

## Structure
- Package `dram_arb_pkg`:
  - Enum `arb_state_t` {IDLE, ACCESS, RESP}.
  - Constants `PORT_CPU`=0 and `PORT_AUX`=1.
  - Localparam for the `wait_cnt` width (4).
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are `valid[1:0]` and `last`; outputs are `grant[1:0]` (one-hot or zero) and `idx`.
- Top level: FSM, latches, counter and output registers.

## Test plan
- **Single read:** port 0 read at 0x0008 with RD_WAIT=1 and `mem_spo`=0xDEADBEEF at `mem_a`=0x0002. Require `req_ready[0]` in cycle 0, `mem_a`=0x0002 in cycle 1, `rsp_valid[0]` with `rsp_rdata`=0xDEADBEEF in cycle 2.
- **Single write:** port 1 writes 0x12345678 to 0x0010. Require `mem_we`=1, `mem_a`=0x0004 and `mem_d`=0x12345678 in cycle 1 only, `rsp_valid[1]` in cycle 2, and `rsp_rdata` unchanged.
- **Contention:** both ports hold valid reads for 4 transactions. Require grant order 0,1,0,1 and each `rsp_valid` routed only to the owner.
- **Wait states:** RD_WAIT=3, with `mem_spo` changing 0xA→0xB→0xC over ACCESS cycles 1..3. Require `rsp_rdata`=0xC in cycle 4.
- **Reset mid-write:** assert `fpga_rst_n`=0 during ACCESS of a write. Require `mem_we` to fall to 0 asynchronously, no `rsp_valid`, and the next tie after release granted to port 0.
- **Early withdraw:** port 1 asserts valid while port 0 is being served, then drops it before IDLE. Require no grant to port 1, no `mem_we`, and no `rsp_valid[1]`.
